pipe_stage_reg: RTL and testbench

//   Generic inter-stage pipeline register for the 5-stage MIPS core (D/E, E/M, M/W).

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage_reg_if.sv | 20 ++
 rtl/pipe_entry_reg.sv | 17 +
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline stage registers.
package pipe_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned TNEW_W  = 5;

   localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(0);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus carrying one pipeline entry between stages.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_DATA = 2,
   parameter int unsigned TNEW_W   = pipe_pkg::TNEW_W
);

   logic                             valid;
   logic                             ready;
   logic [pipe_pkg::INSTR_W-1:0]     instr;
   logic [pipe_pkg::PC_W-1:0]        pc4;
   logic [pipe_pkg::PC_W-1:0]        pc8;
   logic [DATA_W*NUM_DATA-1:0]       data;
   logic [pipe_pkg::REG_W-1:0]       a3;
   logic [TNEW_W-1:0]                tnew;

   modport master (output valid, instr, pc4, pc8, data, a3, tnew, input ready);
   modport slave  (input valid, instr, pc4, pc8, data, a3, tnew, output ready);

endinterface

// File: rtl/pipe_entry_reg.sv
// Single packed pipeline entry register with synchronous clear and load enable.
module pipe_entry_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: head + skid entries, registered in_ready, flush, T_new countdown.
module pipe_stage_reg #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_DATA = 2,
   parameter int unsigned TNEW_W   = pipe_pkg::TNEW_W,
   parameter int unsigned DEC_TNEW = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   pipe_stage_reg_if.slave   in_bus,
   pipe_stage_reg_if.master  out_bus
);

   import pipe_pkg::INSTR_W;
   import pipe_pkg::PC_W;
   import pipe_pkg::REG_W;
   import pipe_pkg::NOP_INSTR;

   localparam int unsigned DW      = DATA_W * NUM_DATA;
   localparam int unsigned ENTRY_W = INSTR_W + 2 * PC_W + DW + REG_W + TNEW_W;

   // A bubble is a NOP with every other field zero, so the hazard unit sees no producer.
   localparam logic [ENTRY_W-1:0] BUBBLE = {NOP_INSTR, (ENTRY_W - INSTR_W)'(0)};

   logic               head_v;
   logic               skid_v;
   logic [ENTRY_W-1:0] head_q;
   logic [ENTRY_W-1:0] skid_q;
   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] head_d;
   logic [ENTRY_W-1:0] skid_d;
   logic [TNEW_W-1:0]  tnew_cap;
   logic               clear;
   logic               accept;
   logic               release_head;
   logic               head_en;
   logic               skid_load;
   logic               skid_move;

   // Saturating T_new countdown applied on capture.
   always_comb begin
      tnew_cap = in_bus.tnew;
      if (DEC_TNEW != 0 && in_bus.tnew != '0)
         tnew_cap = in_bus.tnew - TNEW_W'(1);
   end

   assign in_entry = {in_bus.instr, in_bus.pc4, in_bus.pc8, in_bus.data, in_bus.a3, tnew_cap};

   // Steering: skid always drains into head first, keeping FIFO order.
   always_comb begin
      clear        = reset | flush;
      accept       = in_bus.valid & ~skid_v;
      release_head = head_v & out_bus.ready;
      head_en      = ~head_v | release_head;
      skid_move    = head_en & skid_v;
      skid_load    = head_v & ~release_head & accept;
      head_d       = BUBBLE;
      skid_d       = BUBBLE;
      if (skid_v)      head_d = skid_q;
      else if (accept) head_d = in_entry;
      if (skid_load)   skid_d = in_entry;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         head_v <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         if (head_en)        head_v <= skid_v | accept;
         if (skid_move)      skid_v <= 1'b0;
         else if (skid_load) skid_v <= 1'b1;
      end
   end

   pipe_entry_reg #(.W(ENTRY_W)) u_head (
      .clk   (clk),
      .clear (clear),
      .en    (head_en),
      .d     (head_d),
      .q     (head_q)
   );

   pipe_entry_reg #(.W(ENTRY_W)) u_skid (
      .clk   (clk),
      .clear (clear),
      .en    (skid_load | skid_move),
      .d     (skid_d),
      .q     (skid_q)
   );

   assign in_bus.ready  = ~skid_v;
   assign out_bus.valid = head_v;
   assign {out_bus.instr, out_bus.pc4, out_bus.pc8, out_bus.data, out_bus.a3, out_bus.tnew} = head_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard-checked stimulus for pipe_stage_reg (DEC_TNEW=1 and DEC_TNEW=0 builds).
module tb_pipe_stage_reg;

   logic clk;
   logic reset;
   logic flush;

   int n_checks;
   int n_errors;

   pipe_stage_reg_if #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(5)) in_bus ();
   pipe_stage_reg_if #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(5)) out_bus ();
   pipe_stage_reg_if #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(5)) in_bus0 ();
   pipe_stage_reg_if #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(5)) out_bus0 ();

   pipe_stage_reg #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(5), .DEC_TNEW(1)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .in_bus  (in_bus),
      .out_bus (out_bus)
   );

   pipe_stage_reg #(.DATA_W(32), .NUM_DATA(2), .TNEW_W(5), .DEC_TNEW(0)) dut_nodec (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .in_bus  (in_bus0),
      .out_bus (out_bus0)
   );

   assign in_bus0.valid  = in_bus.valid;
   assign in_bus0.instr  = in_bus.instr;
   assign in_bus0.pc4    = in_bus.pc4;
   assign in_bus0.pc8    = in_bus.pc8;
   assign in_bus0.data   = in_bus.data;
   assign in_bus0.a3     = in_bus.a3;
   assign in_bus0.tnew   = in_bus.tnew;
   assign out_bus0.ready = out_bus.ready;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a3, input logic [4:0] tnew,
                        input logic [31:0] tag);
      in_bus.valid = v;
      in_bus.instr = tag;
      in_bus.pc4   = tag + 32'd4;
      in_bus.pc8   = tag + 32'd8;
      in_bus.data  = {tag ^ 32'hA5A5_A5A5, ~tag};
      in_bus.a3    = a3;
      in_bus.tnew  = tnew;
   endtask

   function automatic logic [255:0] exp_entry(input logic [31:0] tag, input logic [4:0] a3,
                                              input logic [4:0] tnew);
      return 256'({tag, tag + 32'd4, tag + 32'd8, tag ^ 32'hA5A5_A5A5, ~tag, a3, tnew});
   endfunction

   function automatic logic [255:0] obs_entry();
      return 256'({out_bus.instr, out_bus.pc4, out_bus.pc8, out_bus.data, out_bus.a3, out_bus.tnew});
   endfunction

   logic [255:0] sb[$];

   initial begin
      logic        v;
      logic        r;
      logic [4:0]  ra3;
      logic [4:0]  rtn;
      logic [4:0]  tdec;
      bit          acc;
      bit          rel;

      n_checks = 0;
      n_errors = 0;
      clk      = 1'b0;
      reset    = 1'b1;
      flush    = 1'b0;
      out_bus.ready = 1'b0;
      drive(1'b1, 5'd31, 5'd7, 32'hDEAD_0000);

      // Reset held two cycles; the asserted in_valid must be ignored.
      tick();
      tick();
      check_eq("rst_valid", 256'(out_bus.valid), 256'(1'b0));
      check_eq("rst_ready", 256'(in_bus.ready), 256'(1'b1));
      check_eq("rst_a3", 256'(out_bus.a3), 256'(5'd0));
      check_eq("rst_tnew", 256'(out_bus.tnew), 256'(5'd0));
      reset = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      tick();
      check_eq("rst_entry", obs_entry(), 256'(0));

      // Stream of four entries with one-cycle latency and tnew 2 -> 1.
      out_bus.ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 5'(k), 5'd2, 32'h100 * k);
         tick();
         check_eq("stream_valid", 256'(out_bus.valid), 256'(1'b1));
         check_eq("stream_entry", obs_entry(), exp_entry(32'h100 * k, 5'(k), 5'd1));
      end
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      tick();
      check_eq("stream_end_valid", 256'(out_bus.valid), 256'(1'b0));
      check_eq("stream_end_bubble", obs_entry(), 256'(0));

      // T_new saturation and the non-decrementing build.
      drive(1'b1, 5'd9, 5'd0, 32'h900);
      tick();
      check_eq("sat_tnew0", 256'(out_bus.tnew), 256'(5'd0));
      check_eq("nodec_tnew0", 256'(out_bus0.tnew), 256'(5'd0));
      drive(1'b1, 5'd10, 5'd3, 32'hA00);
      tick();
      check_eq("dec_tnew3", 256'(out_bus.tnew), 256'(5'd2));
      check_eq("nodec_tnew3", 256'(out_bus0.tnew), 256'(5'd3));
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      tick();

      // Stall: A held in head, B in skid, C ignored while full.
      out_bus.ready = 1'b0;
      drive(1'b1, 5'd5, 5'd4, 32'hA);
      tick();
      drive(1'b1, 5'd6, 5'd4, 32'hB);
      tick();
      check_eq("stall_head", obs_entry(), exp_entry(32'hA, 5'd5, 5'd3));
      check_eq("stall_ready", 256'(in_bus.ready), 256'(1'b0));
      drive(1'b1, 5'd7, 5'd4, 32'hC);
      tick();
      check_eq("stall_hold_a3", 256'(out_bus.a3), 256'(5'd5));
      check_eq("stall_hold_ready", 256'(in_bus.ready), 256'(1'b0));
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      out_bus.ready = 1'b1;
      tick();
      check_eq("stall_b", obs_entry(), exp_entry(32'hB, 5'd6, 5'd3));
      check_eq("stall_valid_b", 256'(out_bus.valid), 256'(1'b1));
      check_eq("stall_ready_b", 256'(in_bus.ready), 256'(1'b1));
      tick();
      check_eq("stall_drained", 256'(out_bus.valid), 256'(1'b0));

      // Flush with both entries full and a valid input pending.
      out_bus.ready = 1'b0;
      drive(1'b1, 5'd12, 5'd1, 32'hE);
      tick();
      drive(1'b1, 5'd13, 5'd1, 32'hF);
      tick();
      check_eq("flush_pre_ready", 256'(in_bus.ready), 256'(1'b0));
      flush = 1'b1;
      drive(1'b1, 5'd14, 5'd1, 32'h6);
      tick();
      flush = 1'b0;
      check_eq("flush_valid", 256'(out_bus.valid), 256'(1'b0));
      check_eq("flush_ready", 256'(in_bus.ready), 256'(1'b1));
      check_eq("flush_entry", obs_entry(), 256'(0));
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      tick();
      check_eq("flush_dropped", 256'(out_bus.valid), 256'(1'b0));

      // Reset mid-stall discards both entries.
      drive(1'b1, 5'd15, 5'd1, 32'h15);
      tick();
      drive(1'b1, 5'd16, 5'd1, 32'h16);
      tick();
      reset = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      tick();
      reset = 1'b0;
      check_eq("rst_stall_valid", 256'(out_bus.valid), 256'(1'b0));
      check_eq("rst_stall_ready", 256'(in_bus.ready), 256'(1'b1));
      check_eq("rst_stall_entry", obs_entry(), 256'(0));

      // Random handshake traffic against a scoreboard FIFO.
      for (int c = 0; c < 4000; c++) begin
         v   = ($urandom % 4) != 0;
         r   = ($urandom % 3) != 0;
         ra3 = 5'($urandom);
         rtn = 5'($urandom);
         drive(v, ra3, rtn, 32'h1000_0000 + 32'(c));
         out_bus.ready = r;
         check_eq("rnd_valid", 256'(out_bus.valid), 256'(sb.size() > 0));
         check_eq("rnd_ready", 256'(in_bus.ready), 256'(sb.size() < 2));
         if (sb.size() > 0) check_eq("rnd_entry", obs_entry(), sb[0]);
         acc  = v && (sb.size() < 2);
         rel  = (sb.size() > 0) && r;
         tdec = (rtn == 5'd0) ? 5'd0 : rtn - 5'd1;
         tick();
         if (rel) void'(sb.pop_front());
         if (acc) sb.push_back(exp_entry(32'h1000_0000 + 32'(c), ra3, tdec));
      end

      // Bounded drain of whatever is left.
      drive(1'b0, 5'd0, 5'd0, 32'h0);
      out_bus.ready = 1'b1;
      for (int c = 0; c < 4 && sb.size() > 0; c++) begin
         check_eq("drain_entry", obs_entry(), sb[0]);
         void'(sb.pop_front());
         tick();
      end
      check_eq("drain_empty", 256'(sb.size()), 256'(0));
      check_eq("drain_valid", 256'(out_bus.valid), 256'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
